// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: same-cycle hits, word-by-word line refill on a miss,
// global flush. Define ICACHE_STATS_EN to add saturating hit/miss counter ports.
module icache_dm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int LINES  = 16,
  parameter int WORDS  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              req_i,
  output logic [DATA_W-1:0] inst_o,
  output logic              hit_o,
  output logic              stall_o,
  input  logic              flush_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  state_t state, state_next;

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [OFF_W-1:0] req_off;

  logic [TAG_W-1:0] fill_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [OFF_W-1:0] cnt;
  logic             flush_pend;

  logic [DATA_W-1:0] data_arr [LINES*WORDS];
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [LINES-1:0]  valid;

  logic start_refill;
  logic word_ack;
  logic fill_last;
  logic do_flush;
  logic tag_match;

  assign req_tag = addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx = addr_i[OFF_W +: IDX_W];
  assign req_off = addr_i[OFF_W-1:0];

  assign tag_match = (tag_arr[req_idx] == req_tag);
  assign hit_o     = req_i && (state == IDLE) && valid[req_idx] && tag_match;
  assign inst_o    = data_arr[{req_idx, req_off}];

  // Refill address stays inside the latched line; cnt supplies the word offset.
  assign mem_addr_o = {fill_tag, fill_idx, cnt};
  assign word_ack   = (state == REFILL) && mem_ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    start_refill = 1'b0;
    fill_last    = 1'b0;
    do_flush     = 1'b0;
    mem_req_o    = 1'b0;
    stall_o      = 1'b0;
    unique case (state)
      IDLE: begin
        stall_o = req_i && !hit_o;
        if (flush_i) begin
          state_next = FLUSH;
        end else if (req_i && !hit_o) begin
          state_next   = REFILL;
          start_refill = 1'b1;
        end
      end
      REFILL: begin
        mem_req_o = 1'b1;
        stall_o   = 1'b1;
        if (mem_ack_i && (cnt == LAST_WORD)) begin
          fill_last  = 1'b1;
          state_next = FILL_DONE;
        end
      end
      FILL_DONE: begin
        stall_o    = 1'b1;
        state_next = (flush_pend || flush_i) ? FLUSH : IDLE;
      end
      FLUSH: begin
        stall_o    = 1'b1;
        do_flush   = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A flush seen while a refill is in flight is deferred until the line is complete.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid      <= '0;
      cnt        <= '0;
      fill_tag   <= '0;
      fill_idx   <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (start_refill) begin
        fill_tag        <= req_tag;
        fill_idx        <= req_idx;
        cnt             <= '0;
        valid[req_idx]  <= 1'b0;
      end
      if (word_ack) begin
        cnt <= cnt + 1'b1;
      end
      if (fill_last) begin
        valid[fill_idx] <= 1'b1;
      end
      if (do_flush) begin
        valid <= '0;
      end
      if (state_next == FLUSH) begin
        flush_pend <= 1'b0;
      end else if (flush_i && (state == REFILL || state == FILL_DONE)) begin
        flush_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (word_ack) begin
      data_arr[{fill_idx, cnt}] <= mem_data_i;
    end
    if (fill_last) begin
      tag_arr[fill_idx] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  // Counters saturate rather than wrap and survive flushes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit_o && (hit_cnt_o != 32'hFFFF_FFFF)) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
      if (start_refill && (miss_cnt_o != 32'hFFFF_FFFF)) begin
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: directed scenarios plus randomized fetches checked
// against a line-level cache model; checks the stats counters when ICACHE_STATS_EN is set.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] addr = '0;
  logic        req = 1'b0;
  logic [31:0] inst;
  logic        hit;
  logic        stall;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic        mem_ack = 1'b0;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  int tests  = 0;
  int errors = 0;

  // Line-level reference: which tag each line holds, if any.
  bit       m_valid [16];
  bit [9:0] m_tag   [16];
  int       m_hits   = 0;
  int       m_misses = 0;

  int          ack_gap = 0;
  int          r_stalls;
  int          r_acks;
  bit          r_first_hit;
  logic [31:0] r_word;
  bit          r_addr_ok;
  bit          r_timeout;

  icache_dm dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .addr_i     (addr),
    .req_i      (req),
    .inst_o     (inst),
    .hit_o      (hit),
    .stall_o    (stall),
    .flush_i    (flush),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_data_i (mem_data),
    .mem_ack_i  (mem_ack)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return 32'(a) * 32'd3;
  endfunction

  function automatic bit model_hit(input logic [15:0] a);
    return m_valid[a[5:2]] && (m_tag[a[5:2]] == a[15:6]);
  endfunction

  task automatic model_fill(input logic [15:0] a);
    m_valid[a[5:2]] = 1'b1;
    m_tag[a[5:2]]   = a[15:6];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // Hold a request on address a until it hits, acting as the backing memory.
  task automatic fetch(input logic [15:0] a, input int flush_at);
    int          gap;
    logic [15:0] base;
    base        = {a[15:2], 2'b00};
    gap         = 0;
    r_stalls    = 0;
    r_acks      = 0;
    r_first_hit = 1'b0;
    r_word      = '0;
    r_addr_ok   = 1'b1;
    r_timeout   = 1'b1;
    req  = 1'b1;
    addr = a;
    for (int cyc = 0; cyc < 300; cyc++) begin
      mem_ack = 1'b0;
      flush   = 1'b0;
      #1;
      if (hit) begin
        r_first_hit = (cyc == 0);
        r_word      = inst;
        r_timeout   = 1'b0;
        break;
      end
      if (stall) r_stalls++;
      if (mem_req) begin
        if (mem_addr !== base + 16'(r_acks % 4)) r_addr_ok = 1'b0;
        if (gap == ack_gap) begin
          mem_ack  = 1'b1;
          mem_data = mem_word(mem_addr);
          r_acks++;
          gap = 0;
          if (r_acks == flush_at) flush = 1'b1;
        end else begin
          gap++;
        end
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    flush   = 1'b0;
    if (!r_timeout) begin
      m_hits++;
      m_misses += r_acks / 4;
      @(posedge clk); #1;
    end
    req = 1'b0;
  endtask

  task automatic check_fetch(input string name, input bit exp_hit, input int exp_acks,
                             input int exp_stalls, input logic [15:0] a);
    tests++;
    if (r_timeout) begin
      errors++;
      $display("[TB] FAIL %s timeout: no hit within cycle budget", name);
    end
    tests++;
    if (r_first_hit !== exp_hit) begin
      errors++;
      $display("[TB] FAIL %s hit: got %0b expected %0b", name, r_first_hit, exp_hit);
    end
    tests++;
    if (r_word !== mem_word(a)) begin
      errors++;
      $display("[TB] FAIL %s inst: got %h expected %h", name, r_word, mem_word(a));
    end
    tests++;
    if (r_acks !== exp_acks || !r_addr_ok) begin
      errors++;
      $display("[TB] FAIL %s refill: acks %0d addr_ok %0b expected acks %0d addr_ok 1",
               name, r_acks, r_addr_ok, exp_acks);
    end
    if (exp_stalls >= 0) begin
      tests++;
      if (r_stalls !== exp_stalls) begin
        errors++;
        $display("[TB] FAIL %s stalls: got %0d expected %0d", name, r_stalls, exp_stalls);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b1; addr = 16'h0010;
    #1;
    tests++;
    if (hit !== 1'b0 || stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req: hit %b stall %b mem_req %b expected 0 1 0", hit, stall, mem_req);
    end
    req = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b0 || hit !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle: stall %b hit %b expected 0 0", stall, hit);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss_and_reuse();
    ack_gap = 0;
    fetch(16'h0010, -1);
    check_fetch("cold_miss", 1'b0, 4, 6, 16'h0010);
    model_fill(16'h0010);
    for (int i = 1; i < 4; i++) begin
      fetch(16'h0010 + 16'(i), -1);
      check_fetch("line_reuse", 1'b1, 0, 0, 16'h0010 + 16'(i));
    end
`ifdef ICACHE_STATS_EN
    tests++;
    if (miss_cnt !== 32'd1 || hit_cnt !== 32'd4) begin
      errors++;
      $display("[TB] FAIL stats_plan: miss %0d hit %0d expected 1 4", miss_cnt, hit_cnt);
    end
`endif
  endtask

  task automatic test_conflict();
    ack_gap = 0;
    fetch(16'h0050, -1);
    check_fetch("conflict_new", 1'b0, 4, 6, 16'h0050);
    model_fill(16'h0050);
    fetch(16'h0010, -1);
    check_fetch("conflict_back", 1'b0, 4, 6, 16'h0010);
    model_fill(16'h0010);
  endtask

  task automatic test_flush();
    ack_gap = 0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    tests++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_stall: got %b expected 1", stall);
    end
    @(posedge clk); #1;
    tests++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flush_done: got %b expected 0", stall);
    end
    model_clear();
    fetch(16'h0010, -1);
    check_fetch("after_flush", 1'b0, 4, 6, 16'h0010);
    model_fill(16'h0010);
    fetch(16'h0014, 1);
    check_fetch("flush_mid_refill", 1'b0, 8, 13, 16'h0014);
    model_clear();
    model_fill(16'h0014);
    fetch(16'h0010, -1);
    check_fetch("flushed_line", 1'b0, 4, 6, 16'h0010);
    model_fill(16'h0010);
  endtask

  task automatic test_slow_and_reset();
    int acks;
    int gap;
    ack_gap = 2;
    fetch(16'h0024, -1);
    check_fetch("slow_mem", 1'b0, 4, -1, 16'h0024);
    model_fill(16'h0024);
    req = 1'b1; addr = 16'h0088; acks = 0; gap = 0;
    for (int cyc = 0; cyc < 100 && acks < 2; cyc++) begin
      mem_ack = 1'b0;
      #1;
      if (mem_req) begin
        if (gap == 2) begin
          mem_ack  = 1'b1;
          mem_data = mem_word(mem_addr);
          acks++;
          gap = 0;
        end else begin
          gap++;
        end
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    tests++;
    if (acks !== 2) begin
      errors++;
      $display("[TB] FAIL reset_setup: acks %0d expected 2", acks);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (mem_req !== 1'b0 || hit !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_midfill: mem_req %b hit %b stall %b expected 0 0 1", mem_req, hit, stall);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    model_clear();
    m_hits = 0; m_misses = 0;
    req = 1'b0;
    fetch(16'h0088, -1);
    check_fetch("rerequest", 1'b0, 4, -1, 16'h0088);
    model_fill(16'h0088);
    fetch(16'h0024, -1);
    check_fetch("reset_cleared", 1'b0, 4, -1, 16'h0024);
    model_fill(16'h0024);
  endtask

  task automatic test_random();
    logic [15:0] a;
    bit          exp;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(9) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        model_clear();
      end
      ack_gap = int'($urandom_range(2));
      a   = {8'h00, 2'($urandom_range(3)), 4'($urandom_range(15)), 2'($urandom_range(3))};
      exp = model_hit(a);
      fetch(a, -1);
      check_fetch("random", exp, exp ? 0 : 4, (exp || ack_gap != 0) ? (exp ? 0 : -1) : 6, a);
      model_fill(a);
    end
`ifdef ICACHE_STATS_EN
    tests++;
    if (hit_cnt !== 32'(m_hits) || miss_cnt !== 32'(m_misses)) begin
      errors++;
      $display("[TB] FAIL stats_random: hit %0d miss %0d expected %0d %0d",
               hit_cnt, miss_cnt, m_hits, m_misses);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_cold_miss_and_reuse();
    test_conflict();
    test_flush();
    test_slow_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
